// File: rtl/mycpu_bus_arbiter.sv
// rtl/mycpu_bus_arbiter.sv - CPU/DMA shared-bus arbiter with fixed wait-state access sequencing
module mycpu_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int FAIR        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_a,
  input  logic [15:0] cpu_d,
  input  logic        cpu_wen,
  input  logic        cpu_iom,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_a,
  input  logic [15:0] dma_d,
  input  logic        dma_wen,
  input  logic        dma_iom,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] a_out,
  output logic [15:0] d_out,
  output logic        wen_out,
  output logic        iom_out,
  input  logic [15:0] d_in,
  input  logic [15:0] io_in,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        last_owner, last_owner_nx;
  logic        lat_wen, lat_wen_nx;
  logic [15:0] a_nx, d_nx, cpu_rdata_nx, dma_rdata_nx;
  logic        wen_nx, iom_nx, owner_nx, busy_nx, cpu_ack_nx, dma_ack_nx;
  logic        grant_dma;
  logic [15:0] rd_val;

  // On a tie, FAIR hands the bus to whoever did not complete the last access
  assign grant_dma = dma_req && (!cpu_req || ((FAIR != 0) && (last_owner == 1'b0)));
  assign rd_val    = iom_out ? io_in : d_in;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    last_owner_nx = last_owner;
    lat_wen_nx    = lat_wen;
    a_nx          = 16'h0000;
    d_nx          = 16'h0000;
    wen_nx        = 1'b0;
    iom_nx        = 1'b0;
    owner_nx      = owner;
    cpu_ack_nx    = 1'b0;
    dma_ack_nx    = 1'b0;
    cpu_rdata_nx  = cpu_rdata;
    dma_rdata_nx  = dma_rdata;
    case (state)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          state_nx   = S_ACCESS;
          cnt_nx     = 4'(WAIT_CYCLES);
          owner_nx   = grant_dma;
          a_nx       = grant_dma ? dma_a   : cpu_a;
          d_nx       = grant_dma ? dma_d   : cpu_d;
          iom_nx     = grant_dma ? dma_iom : cpu_iom;
          wen_nx     = grant_dma ? dma_wen : cpu_wen;
          lat_wen_nx = wen_nx;
        end
      end
      S_ACCESS: begin
        if (cnt != 4'd0) begin
          // hold address/data/space; the write strobe is only ever one cycle wide
          cnt_nx = cnt - 4'd1;
          a_nx   = a_out;
          d_nx   = d_out;
          iom_nx = iom_out;
        end else begin
          state_nx      = S_ACK;
          last_owner_nx = owner;
          cpu_ack_nx    = !owner;
          dma_ack_nx    = owner;
          if (!lat_wen) begin
            if (owner) dma_rdata_nx = rd_val;
            else       cpu_rdata_nx = rd_val;
          end
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      last_owner <= 1'b1;
      lat_wen    <= 1'b0;
      a_out      <= 16'h0000;
      d_out      <= 16'h0000;
      wen_out    <= 1'b0;
      iom_out    <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= 16'h0000;
      dma_rdata  <= 16'h0000;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_owner <= last_owner_nx;
      lat_wen    <= lat_wen_nx;
      a_out      <= a_nx;
      d_out      <= d_nx;
      wen_out    <= wen_nx;
      iom_out    <= iom_nx;
      owner      <= owner_nx;
      busy       <= busy_nx;
      cpu_ack    <= cpu_ack_nx;
      dma_ack    <= dma_ack_nx;
      cpu_rdata  <= cpu_rdata_nx;
      dma_rdata  <= dma_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mycpu_bus_arbiter.sv
// tb/tb_mycpu_bus_arbiter.sv - randomized transaction-level check of three arbiter configurations
module tb_mycpu_bus_arbiter;

  localparam int ND = 3;
  localparam logic [11:0] WCS = {4'd15, 4'd0, 4'd1};
  localparam logic [2:0]  FRS = 3'b101;
  localparam int N_ITER = 3000;
  localparam int RST_IT = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  logic        cpu_req [ND], cpu_wen [ND], cpu_iom [ND], cpu_ack [ND];
  logic [15:0] cpu_a [ND], cpu_d [ND], cpu_rdata [ND];
  logic        dma_req [ND], dma_wen [ND], dma_iom [ND], dma_ack [ND];
  logic [15:0] dma_a [ND], dma_d [ND], dma_rdata [ND];
  logic [15:0] a_out [ND], d_out [ND], d_in [ND], io_in [ND];
  logic        wen_out [ND], iom_out [ND], busy [ND], owner [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mycpu_bus_arbiter #(.WAIT_CYCLES(int'(WCS[g*4 +: 4])), .FAIR(int'(FRS[g]))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[g]), .cpu_a(cpu_a[g]), .cpu_d(cpu_d[g]), .cpu_wen(cpu_wen[g]),
      .cpu_iom(cpu_iom[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .dma_req(dma_req[g]), .dma_a(dma_a[g]), .dma_d(dma_d[g]), .dma_wen(dma_wen[g]),
      .dma_iom(dma_iom[g]), .dma_ack(dma_ack[g]), .dma_rdata(dma_rdata[g]),
      .a_out(a_out[g]), .d_out(d_out[g]), .wen_out(wen_out[g]), .iom_out(iom_out[g]),
      .d_in(d_in[g]), .io_in(io_in[g]), .busy(busy[g]), .owner(owner[g])
    );
  end

  // Reference model: one in-flight transaction per instance, described by its grant cycle
  logic        m_active [ND];
  int          m_gcyc [ND], m_ack [ND], m_idle [ND];
  logic        m_own [ND], m_last [ND], m_owner_out [ND];
  logic [15:0] m_a [ND], m_d [ND], m_exp [ND];
  logic        m_wen [ND], m_iom [ND];
  logic [15:0] m_rd [ND][2];
  int          r_delay [ND][2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_f(input logic [15:0] a, input int n);
    return (a ^ 16'h5A5A) + 16'(n * 3);
  endfunction

  function automatic logic [15:0] io_f(input logic [15:0] a, input int n);
    return ~a + 16'(n * 5);
  endfunction

  function automatic int wc(input int g);
    return int'(WCS[g*4 +: 4]);
  endfunction

  task automatic model_reset();
    for (int g = 0; g < ND; g++) begin
      m_active[g] = 1'b0;
      m_last[g] = 1'b1;
      m_owner_out[g] = 1'b0;
      m_rd[g][0] = 16'h0;
      m_rd[g][1] = 16'h0;
    end
  endtask

  task automatic check_zero(input int g, input string when);
    check_eq($sformatf("d%0d rst_bus %s", g, when),
             {a_out[g], d_out[g]}, 32'h0);
    check_eq($sformatf("d%0d rst_ctl %s", g, when),
             {26'h0, wen_out[g], iom_out[g], busy[g], owner[g], cpu_ack[g], dma_ack[g]}, 32'h0);
    check_eq($sformatf("d%0d rst_rdata %s", g, when), {cpu_rdata[g], dma_rdata[g]}, 32'h0);
    check_eq($sformatf("d%0d rst_x %s", g, when),
             32'($isunknown({a_out[g], d_out[g], wen_out[g], iom_out[g], busy[g], owner[g],
                             cpu_ack[g], dma_ack[g], cpu_rdata[g], dma_rdata[g]})), 32'h0);
  endtask

  task automatic new_txn(input int g, input int p);
    if (p == 0) begin
      cpu_req[g] = 1'b1; cpu_a[g] = 16'($urandom); cpu_d[g] = 16'($urandom);
      cpu_wen[g] = 1'($urandom); cpu_iom[g] = 1'($urandom);
    end else begin
      dma_req[g] = 1'b1; dma_a[g] = 16'($urandom); dma_d[g] = 16'($urandom);
      dma_wen[g] = 1'($urandom); dma_iom[g] = 1'($urandom);
    end
  endtask

  task automatic cycle_body(input int g, input int n);
    logic acc, ackc, idle, both, gd, req;
    // ack cycle: completion becomes visible together with the captured read data
    ackc = m_active[g] && (n == m_ack[g]);
    if (ackc) begin
      m_last[g] = m_own[g];
      if (!m_wen[g]) m_rd[g][m_own[g]] = m_exp[g];
    end
    acc = m_active[g] && (n > m_gcyc[g]) && (n < m_ack[g]);
    check_eq($sformatf("d%0d a_out@%0d", g, n), 32'(a_out[g]), acc ? 32'(m_a[g]) : 32'h0);
    check_eq($sformatf("d%0d d_out@%0d", g, n), 32'(d_out[g]), acc ? 32'(m_d[g]) : 32'h0);
    check_eq($sformatf("d%0d iom_out@%0d", g, n), 32'(iom_out[g]), acc ? 32'(m_iom[g]) : 32'h0);
    check_eq($sformatf("d%0d wen_out@%0d", g, n), 32'(wen_out[g]),
             (acc && n == m_gcyc[g] + 1) ? 32'(m_wen[g]) : 32'h0);
    check_eq($sformatf("d%0d acks@%0d", g, n), {30'h0, cpu_ack[g], dma_ack[g]},
             {30'h0, ackc && !m_own[g], ackc && m_own[g]});
    check_eq($sformatf("d%0d busy@%0d", g, n), 32'(busy[g]),
             32'(m_active[g] && n > m_gcyc[g] && n <= m_ack[g]));
    check_eq($sformatf("d%0d owner@%0d", g, n), 32'(owner[g]), 32'(m_owner_out[g]));
    check_eq($sformatf("d%0d rdata@%0d", g, n), {cpu_rdata[g], dma_rdata[g]},
             {m_rd[g][0], m_rd[g][1]});

    for (int p = 0; p < 2; p++) begin
      req = (p == 0) ? cpu_req[g] : dma_req[g];
      if (ackc && m_own[g] == 1'(p)) begin
        if ($urandom_range(2) == 0) new_txn(g, p);
        else begin
          if (p == 0) cpu_req[g] = 1'b0; else dma_req[g] = 1'b0;
          r_delay[g][p] = $urandom_range(3);
        end
      end else if (!req) begin
        if (r_delay[g][p] == 0) begin
          if ($urandom_range(1) == 1) new_txn(g, p);
        end else r_delay[g][p]--;
      end
    end

    idle = !m_active[g] || (n >= m_idle[g]);
    if (idle && (cpu_req[g] || dma_req[g])) begin
      both = cpu_req[g] && dma_req[g];
      if (both) gd = FRS[g] ? !m_last[g] : 1'b0;
      else      gd = dma_req[g];
      m_active[g] = 1'b1;
      m_gcyc[g] = n;
      m_ack[g] = n + wc(g) + 2;
      m_idle[g] = n + wc(g) + 3;
      m_own[g] = gd;
      m_owner_out[g] = gd;
      m_a[g] = gd ? dma_a[g] : cpu_a[g];
      m_d[g] = gd ? dma_d[g] : cpu_d[g];
      m_wen[g] = gd ? dma_wen[g] : cpu_wen[g];
      m_iom[g] = gd ? dma_iom[g] : cpu_iom[g];
      m_exp[g] = m_iom[g] ? io_f(m_a[g], n + wc(g) + 1) : mem_f(m_a[g], n + wc(g) + 1);
    end else if (idle) begin
      m_active[g] = 1'b0;
    end

    d_in[g] = mem_f(a_out[g], n);
    io_in[g] = io_f(a_out[g], n);
  endtask

  initial begin
    for (int g = 0; g < ND; g++) begin
      cpu_req[g] = 1'b0; cpu_a[g] = 16'h0; cpu_d[g] = 16'h0; cpu_wen[g] = 1'b0; cpu_iom[g] = 1'b0;
      dma_req[g] = 1'b0; dma_a[g] = 16'h0; dma_d[g] = 16'h0; dma_wen[g] = 1'b0; dma_iom[g] = 1'b0;
      d_in[g] = 16'h0; io_in[g] = 16'h0;
      r_delay[g][0] = 0; r_delay[g][1] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < ND; g++) check_zero(g, "init");
    rst_n = 1'b1;
    for (int it = 0; it < N_ITER; it++) begin
      if (it == RST_IT) begin
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < ND; g++) check_zero(g, "async");
        model_reset();
        @(negedge clk);
        for (int g = 0; g < ND; g++) check_zero(g, "held");
        rst_n = 1'b1;
      end
      for (int g = 0; g < ND; g++) cycle_body(g, cyc);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
